// File: rtl/invader_formation_drawer.sv
// Alien formation renderer: per-pixel sprite hit test against a marching grid,
// plus the march FSM, per-invader alive bitmap and collision-driven kills.
module invader_formation_drawer #(
    parameter int         COLS            = 8,
    parameter int         ROWS            = 4,
    parameter int         CELL_W          = 32,
    parameter int         CELL_H          = 32,
    parameter int         SPR_W           = 24,
    parameter int         SPR_H           = 16,
    parameter int         START_X         = 64,
    parameter int         START_Y         = 32,
    parameter int         STEP_X          = 8,
    parameter int         STEP_Y          = 16,
    parameter int         FRAMES_PER_STEP = 4,
    parameter int         SCREEN_W        = 640,
    parameter int         LANDING_Y       = 400,
    parameter logic [7:0] INVADER_RGB     = 8'hFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        start,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        collision,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        allDead,
    output logic        landed
);

    localparam int N      = COLS * ROWS;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW_LOG = $clog2(CELL_W);
    localparam int CH_LOG = $clog2(CELL_H);
    localparam int FC_W   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [10:0]     GRID_W     = 11'(COLS * CELL_W);
    localparam logic [10:0]     GRID_H     = 11'(ROWS * CELL_H);
    localparam logic [10:0]     CELL_X_MSK = 11'(CELL_W - 1);
    localparam logic [10:0]     CELL_Y_MSK = 11'(CELL_H - 1);
    localparam logic [11:0]     RIGHT_ADD  = 12'(STEP_X + COLS * CELL_W);
    localparam logic [11:0]     RIGHT_LIM  = 12'(SCREEN_W);
    localparam logic [11:0]     LAND_LIM   = 12'(LANDING_Y);
    localparam logic [FC_W-1:0] FC_LAST    = FC_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {IDLE, RIGHT, LEFT, LANDED, DONE} state_t;

    state_t         state;
    logic [N-1:0]   alive;
    logic [FC_W-1:0] frame_cnt;
    logic [IDX_W-1:0] hit_idx_p1;

    logic [10:0]      off_x_p0, off_y_p0, cell_x_p0, cell_y_p0, col_p0, row_p0;
    logic             in_grid_p0, hit_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [10:0]      down_y;
    logic             down_lands;

    // Stage p0: classify the scan position against the current origin
    always_comb begin
        off_x_p0   = pixelX - topLeftX;
        off_y_p0   = pixelY - topLeftY;
        cell_x_p0  = off_x_p0 & CELL_X_MSK;
        cell_y_p0  = off_y_p0 & CELL_Y_MSK;
        col_p0     = off_x_p0 >> CW_LOG;
        row_p0     = off_y_p0 >> CH_LOG;
        in_grid_p0 = (off_x_p0 < GRID_W) && (off_y_p0 < GRID_H);
        idx_p0     = in_grid_p0 ? IDX_W'(row_p0 * COLS + col_p0) : '0;
        hit_p0     = in_grid_p0 && (cell_x_p0 < 11'(SPR_W)) &&
                     (cell_y_p0 < 11'(SPR_H)) && alive[idx_p0];
    end

    always_comb begin
        down_y     = topLeftY + 11'(STEP_Y);
        down_lands = ({1'b0, down_y} + 12'(ROWS * CELL_H)) >= LAND_LIM;
    end

    // Stage p1: registered drawing outputs and the index they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'h00;
            hit_idx_p1     <= '0;
        end else begin
            drawingRequest <= hit_p0;
            RGBout         <= hit_p0 ? INVADER_RGB : 8'h00;
            hit_idx_p1     <= idx_p0;
        end
    end

    // March FSM, alive bitmap and kill; start overrides any same-cycle kill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            topLeftX  <= 11'(START_X);
            topLeftY  <= 11'(START_Y);
            alive     <= '1;
            frame_cnt <= '0;
            allDead   <= 1'b0;
            landed    <= 1'b0;
        end else begin
            allDead <= (alive == '0);
            if (collision && drawingRequest) begin
                alive[hit_idx_p1] <= 1'b0;
            end
            if (start) begin
                state     <= RIGHT;
                topLeftX  <= 11'(START_X);
                topLeftY  <= 11'(START_Y);
                alive     <= '1;
                frame_cnt <= '0;
                allDead   <= 1'b0;
                landed    <= 1'b0;
            end else begin
                case (state)
                    RIGHT, LEFT: begin
                        if (allDead) begin
                            state <= DONE;
                        end else if (startOfFrame) begin
                            if (frame_cnt == FC_LAST) begin
                                frame_cnt <= '0;
                                if (state == RIGHT &&
                                    ({1'b0, topLeftX} + RIGHT_ADD) <= RIGHT_LIM) begin
                                    topLeftX <= topLeftX + 11'(STEP_X);
                                end else if (state == LEFT && topLeftX >= 11'(STEP_X)) begin
                                    topLeftX <= topLeftX - 11'(STEP_X);
                                end else begin
                                    topLeftY <= down_y;
                                    if (down_lands) begin
                                        landed <= 1'b1;
                                        state  <= LANDED;
                                    end else begin
                                        state <= (state == RIGHT) ? LEFT : RIGHT;
                                    end
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_invader_formation_drawer.sv
// Bench for invader_formation_drawer: table of scan vectors, scoreboarded pixel
// outputs, and hand-written march, landing, kill and reset sequences.
module tb_invader_formation_drawer;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, start, collision;
    logic [10:0] pixelX, pixelY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [10:0] topLeftX, topLeftY;
    logic        allDead, landed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        dr;
    } vec_t;

    typedef struct {
        logic       dr;
        logic [7:0] rgb;
    } exp_t;

    vec_t tbl[10];
    exp_t sb[$];

    invader_formation_drawer dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
        .pixelX(pixelX), .pixelY(pixelY), .collision(collision),
        .drawingRequest(drawingRequest), .RGBout(RGBout),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .allDead(allDead), .landed(landed)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic dr);
        exp_t e;
        e.dr  = dr;
        e.rgb = dr ? 8'hFC : 8'h00;
        sb.push_back(e);
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk(nm, {23'd0, drawingRequest, RGBout}, {23'd0, e.dr, e.rgb});
        end
    endtask

    task automatic scan(input logic [10:0] x, input logic [10:0] y, input logic dr,
                        input string nm);
        pixelX = x;
        pixelY = y;
        push_exp(dr);
        @(posedge clk); #1;
        check_out(nm);
    endtask

    // Scan a live sprite pixel, then pulse collision during its output cycle
    task automatic kill(input logic [10:0] x, input logic [10:0] y, input string nm);
        scan(x, y, 1'b1, nm);
        collision = 1'b1;
        pixelX    = 11'd0;
        pixelY    = 11'd0;
        push_exp(1'b0);
        @(posedge clk); #1;
        collision = 1'b0;
        check_out({nm, "_off"});
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            @(posedge clk); #1;
            startOfFrame = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_dr"},      {31'd0, drawingRequest}, 0);
        chk({nm, "_rgb"},     {24'd0, RGBout}, 0);
        chk({nm, "_x"},       {21'd0, topLeftX}, 64);
        chk({nm, "_y"},       {21'd0, topLeftY}, 32);
        chk({nm, "_alldead"}, {31'd0, allDead}, 0);
        chk({nm, "_landed"},  {31'd0, landed}, 0);
    endtask

    initial begin
        int nf;
        tbl[0] = '{11'd64,  11'd32,  1'b1};
        tbl[1] = '{11'd88,  11'd32,  1'b0};
        tbl[2] = '{11'd63,  11'd32,  1'b0};
        tbl[3] = '{11'd87,  11'd47,  1'b1};
        tbl[4] = '{11'd87,  11'd48,  1'b0};
        tbl[5] = '{11'd311, 11'd32,  1'b1};
        tbl[6] = '{11'd320, 11'd32,  1'b0};
        tbl[7] = '{11'd311, 11'd143, 1'b1};
        tbl[8] = '{11'd64,  11'd160, 1'b0};
        tbl[9] = '{11'd0,   11'd0,   1'b0};

        reset = 1'b0; startOfFrame = 1'b0; start = 1'b0; collision = 1'b0;
        pixelX = 11'd0; pixelY = 11'd0;
        #1 reset = 1'b1;
        #2;
        chk_reset_vals("por");
        @(posedge clk); #1;
        reset = 1'b0;

        frames(4);
        chk("idle_hold_x", {21'd0, topLeftX}, 64);
        pulse_start();

        for (int i = 0; i < 10; i++) begin
            scan(tbl[i].x, tbl[i].y, tbl[i].dr, $sformatf("tbl%0d", i));
        end

        kill(11'd96, 11'd32, "kill_c1");
        scan(11'd100, 11'd40, 1'b0, "dead_c1");
        scan(11'd64, 11'd32, 1'b1, "alive_c0");

        pixelX = 11'd88; pixelY = 11'd32;
        push_exp(1'b0);
        @(posedge clk); #1;
        check_out("gap_pixel");
        collision = 1'b1;
        pixelX = 11'd64; pixelY = 11'd32;
        push_exp(1'b1);
        @(posedge clk); #1;
        collision = 1'b0;
        check_out("coll_ignored_cycle");
        scan(11'd64, 11'd32, 1'b1, "no_kill_when_dr0");

        frames(4);
        chk("step1_x", {21'd0, topLeftX}, 72);
        frames(156);
        chk("step40_x", {21'd0, topLeftX}, 384);
        chk("step40_y", {21'd0, topLeftY}, 32);
        frames(4);
        chk("down1_y", {21'd0, topLeftY}, 48);
        chk("down1_x", {21'd0, topLeftX}, 384);
        frames(4);
        chk("left1_x", {21'd0, topLeftX}, 376);

        nf = 0;
        while (!landed && nf < 4000) begin
            frames(1);
            nf++;
        end
        chk("land_frames", nf, 2740);
        chk("land_y", {21'd0, topLeftY}, 272);
        chk("land_x", {21'd0, topLeftX}, 384);
        chk("landed", {31'd0, landed}, 1);
        frames(8);
        chk("land_frozen_x", {21'd0, topLeftX}, 384);
        chk("land_frozen_y", {21'd0, topLeftY}, 272);
        pulse_start();
        chk("restart_x", {21'd0, topLeftX}, 64);
        chk("restart_y", {21'd0, topLeftY}, 32);
        chk("restart_landed", {31'd0, landed}, 0);

        scan(11'd96, 11'd32, 1'b1, "start_restores_alive");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                kill(11'(64 + 32 * c + 4), 11'(32 + 32 * r + 4), $sformatf("kill_%0d", r * 8 + c));
            end
        end
        chk("alldead_not_yet", {31'd0, allDead}, 0);
        @(posedge clk); #1;
        chk("alldead", {31'd0, allDead}, 1);
        scan(11'd64, 11'd32, 1'b0, "all_dead_pixel");
        frames(8);
        chk("done_frozen_x", {21'd0, topLeftX}, 64);
        chk("done_frozen_y", {21'd0, topLeftY}, 32);

        pulse_start();
        frames(68);
        chk("march_200_x", {21'd0, topLeftX}, 200);
        scan(11'd200, 11'd32, 1'b1, "pre_reset_pixel");
        collision = 1'b1;
        startOfFrame = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0; collision = 1'b0; startOfFrame = 1'b0;
        chk("rst_hold_x", {21'd0, topLeftX}, 64);
        chk("rst_hold_y", {21'd0, topLeftY}, 32);
        scan(11'd64, 11'd32, 1'b1, "rst_no_kill");
        frames(4);
        chk("rst_idle_x", {21'd0, topLeftX}, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
